mem_arbiter_rr: RTL and testbench
=================================

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2: number of requester ports; legal range 2..8.
REQ-002 The block SHALL have parameter LINE_WIDTH, default 256: line data width in bits.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32: address width in bits.
REQ-004 The block SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port req_read, input, NUM_PORTS: per-port line read request.
REQ-008 The block SHALL have port req_write, input, NUM_PORTS: per-port line write request.
REQ-009 The block SHALL have port req_address, input, NUM_PORTS*ADDR_WIDTH: per-port address; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 The block SHALL have port req_wdata, input, NUM_PORTS*LINE_WIDTH: per-port write line, packed the same way.
REQ-011 The block SHALL have port req_rdata, output, LINE_WIDTH: read line, shared by all ports.
REQ-012 The block SHALL have port req_resp, output, NUM_PORTS: per-port one-cycle completion pulse.
REQ-013 The block SHALL have ports pmem_read (output, 1), pmem_write (output, 1), pmem_address (output, ADDR_WIDTH), pmem_wdata (output, LINE_WIDTH), pmem_rdata (input, LINE_WIDTH) and pmem_resp (input, 1): the downstream memory interface.
REQ-014 The block SHALL have port grant_id, output, 3: index of the port that owns the current transaction, valid while busy is high.
REQ-015 The block SHALL have port busy, output, 1: high while a transaction is outstanding.

Function
REQ-016 Handshake: a requester SHALL hold read or write, address and wdata stable until it sees its req_resp; a port is requesting when read or write is high.
REQ-017 FSM states: IDLE and BUSY.
REQ-018 Move from IDLE to BUSY when any port is requesting; register the winner index, its address, its wdata and the operation (write if req_write is high, else read).
REQ-019 Move from BUSY to IDLE in the cycle after pmem_resp is sampled high.
REQ-020 In BUSY, pmem_read/pmem_write SHALL be driven from the registered operation, with pmem_address/pmem_wdata from the registered values.
REQ-021 In IDLE, pmem_read and pmem_write SHALL be 0.
REQ-022 Latency: request seen in IDLE at cycle N -> pmem strobe high at cycle N+1.
REQ-023 req_resp[grant_id] SHALL be combinationally equal to pmem_resp while in BUSY, and 0 for every other port and in IDLE.
REQ-024 req_rdata SHALL equal pmem_rdata at all times (pass-through).
REQ-025 Round-robin (ARB_MODE=0): search ports starting at rr_ptr, ascending, wrapping modulo NUM_PORTS; first requesting port wins.
REQ-026 On each completed transaction, rr_ptr SHALL be set to (grant+1) mod NUM_PORTS; the wrap from NUM_PORTS-1 goes to 0.
REQ-027 Fixed priority (ARB_MODE=1): the lowest-index requesting port wins and rr_ptr is ignored.
REQ-028 Back-to-back: at least one IDLE cycle SHALL separate transactions; arbitration happens only in IDLE.
REQ-029 If req_read and req_write are both high on one port, the block SHALL perform a write.
REQ-030 A requester dropping its request mid-transaction SHALL NOT abort the transaction; it completes and the pulse is still issued.
REQ-031 If pmem_resp is high in IDLE, it SHALL be ignored.
REQ-032 Starvation bound (ARB_MODE=0): a continuously requesting port SHALL be granted within NUM_PORTS transactions.

Reset
REQ-033 While rst_n is low, asynchronously: state = IDLE, rr_ptr = 0, grant = 0, and registered address/wdata/operation = 0.
REQ-034 While rst_n is low: pmem_read = 0, pmem_write = 0, busy = 0, grant_id = 0, req_resp = 0.
REQ-035 Reset asserted in BUSY SHALL drop the pmem strobes immediately; the transaction is lost and no req_resp is issued.

Verification
REQ-036 Single read: port1 reads 0x0000_0040 -> next cycle pmem_read=1 with address 0x40; memory responds after 3 cycles with data A -> req_resp[1] pulses once with req_rdata=A, then busy=0.
REQ-037 Round-robin contention: NUM_PORTS=4 and all ports requesting continuously -> grant order 0,1,2,3,0, each grant separated by one IDLE cycle.
REQ-038 Fixed priority: ARB_MODE=1 with ports 0 and 2 requesting -> port 0 is served on every grant while it keeps requesting.
REQ-039 Read and write on the same port: port0 asserts both with wdata=0xDEAD... -> pmem_write=1, pmem_read=0, pmem_wdata equals port0 wdata.
REQ-040 Reset mid-operation: rst_n pulled low in BUSY -> same-cycle pmem_read=0 and busy=0; after release, rr_ptr=0 and a port0 request is granted first.
REQ-041 Spurious response: pmem_resp pulsed in IDLE -> no req_resp pulse and no state change.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
//   Shares one downstream line-memory port among NUM_PORTS requesters. Each
//   transaction is a single line read or write. Arbitration is round-robin
//   (ARB_MODE=0) or fixed priority with port 0 highest (ARB_MODE=1). It happens
//   only in IDLE, so at least one IDLE cycle separates transactions.
//
// Ports
//   clk, rst_n       clock and asynchronous active-low reset
//   req_read         per-port read request
//   req_write        per-port write request (wins over read on the same port)
//   req_address      per-port address, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata        per-port write line, port k at [k*LINE_WIDTH +: LINE_WIDTH]
//   req_rdata        read line, pass-through of pmem_rdata
//   req_resp         per-port completion pulse, mirrors pmem_resp for the owner
//   pmem_*           downstream memory interface
//   grant_id         owner of the current transaction (valid while busy)
//   busy             a transaction is outstanding
// -----------------------------------------------------------------------------
module mem_arbiter_rr #(
   parameter int NUM_PORTS  = 2,
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int ARB_MODE   = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0]             req_read,
   input  logic [NUM_PORTS-1:0]             req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
   output logic [LINE_WIDTH-1:0]            req_rdata,
   output logic [NUM_PORTS-1:0]             req_resp,
   output logic                             pmem_read,
   output logic                             pmem_write,
   output logic [ADDR_WIDTH-1:0]            pmem_address,
   output logic [LINE_WIDTH-1:0]            pmem_wdata,
   input  logic [LINE_WIDTH-1:0]            pmem_rdata,
   input  logic                             pmem_resp,
   output logic [2:0]                       grant_id,
   output logic                             busy
);

   localparam int         IDX_W     = $clog2(NUM_PORTS);
   localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_e;

   state_e                 state_q, state_d;
   logic [2:0]             rr_ptr_q, rr_ptr_d;
   logic [2:0]             grant_q, grant_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   write_q, write_d;

   logic [NUM_PORTS-1:0]   requesting;
   logic                   any_req;
   logic [2:0]             win_idx;
   logic                   win_write;
   logic [ADDR_WIDTH-1:0]  win_addr;
   logic [LINE_WIDTH-1:0]  win_wdata;
   int                     cand;

   assign requesting = req_read | req_write;

   // Winner search. Round-robin walks upward from rr_ptr and wraps; fixed
   // priority walks upward from port 0. The first requester found wins and
   // its operation, address and line are captured alongside the index.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned and no latch is inferred.
      any_req   = 1'b0;
      win_idx   = '0;
      win_write = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      cand      = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (ARB_MODE == 1) begin
            cand = i;
         end else begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
         end
         if (!any_req && requesting[IDX_W'(cand)]) begin
            any_req   = 1'b1;
            win_idx   = 3'(cand);
            win_write = req_write[IDX_W'(cand)];
            win_addr  = req_address[cand*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = req_wdata[cand*LINE_WIDTH +: LINE_WIDTH];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      case (state_q)
         ST_IDLE: begin
            // pmem_resp is deliberately ignored here.
            if (any_req) begin
               state_d = ST_BUSY;
               grant_d = win_idx;
               addr_d  = win_addr;
               wdata_d = win_wdata;
               write_d = win_write;
            end
         end
         ST_BUSY: begin
            // The requester may drop its request meanwhile; only the memory
            // response ends the transaction.
            if (pmem_resp) begin
               state_d  = ST_IDLE;
               rr_ptr_d = (grant_q == LAST_PORT) ? 3'd0 : grant_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others. The wide address/line holders are
   // ordinary flops here, so they take the reset like the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
      end
   end

   // Strobes derive straight from the state flop, so an asynchronous reset
   // in BUSY drops them in the same cycle and no completion pulse follows.
   assign busy         = (state_q == ST_BUSY);
   assign pmem_read    = busy & ~write_q;
   assign pmem_write   = busy & write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign req_rdata    = pmem_rdata;
   assign grant_id     = grant_q;

   always_comb begin
      req_resp = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         req_resp[k] = busy && (grant_q == 3'(k)) && pmem_resp;
      end
   end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_rr
//   Directed bench for mem_arbiter_rr. Two 4-port instances, one round-robin
//   and one fixed priority, see identical stimulus and run in lockstep because
//   both leave IDLE whenever anything requests and both finish on the shared
//   pmem_resp. Expected values are written out by hand at each step.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_rr;

   localparam int NP = 4;
   localparam int LW = 64;
   localparam int AW = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NP-1:0]     req_read;
   logic [NP-1:0]     req_write;
   logic [NP*AW-1:0]  req_address;
   logic [NP*LW-1:0]  req_wdata;
   logic [LW-1:0]     pmem_rdata;
   logic              pmem_resp;

   logic [LW-1:0]     rr_rdata, fp_rdata;
   logic [NP-1:0]     rr_resp, fp_resp;
   logic              rr_pread, fp_pread, rr_pwrite, fp_pwrite;
   logic [AW-1:0]     rr_paddr, fp_paddr;
   logic [LW-1:0]     rr_pwdata, fp_pwdata;
   logic [2:0]        rr_grant, fp_grant;
   logic              rr_busy, fp_busy;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter_rr #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ARB_MODE(0)) u_rr (
      .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
      .req_address(req_address), .req_wdata(req_wdata), .req_rdata(rr_rdata),
      .req_resp(rr_resp), .pmem_read(rr_pread), .pmem_write(rr_pwrite),
      .pmem_address(rr_paddr), .pmem_wdata(rr_pwdata), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp), .grant_id(rr_grant), .busy(rr_busy)
   );

   mem_arbiter_rr #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ARB_MODE(1)) u_fp (
      .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
      .req_address(req_address), .req_wdata(req_wdata), .req_rdata(fp_rdata),
      .req_resp(fp_resp), .pmem_read(fp_pread), .pmem_write(fp_pwrite),
      .pmem_address(fp_paddr), .pmem_wdata(fp_pwdata), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp), .grant_id(fp_grant), .busy(fp_busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle past the edge before driving or sampling.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_addr(input int port, input logic [AW-1:0] a);
      req_address[port*AW +: AW] = a;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] rr_order [5];
      logic [2:0] rr_pair  [3];
      rr_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      rr_pair  = '{3'd2, 3'd0, 3'd2};

      rst_n       = 1'b0;
      req_read    = '0;
      req_write   = '0;
      req_address = '0;
      req_wdata   = '0;
      pmem_rdata  = '0;
      pmem_resp   = 1'b0;
      #1;

      // Reset state.
      check("rst_pmem_read",  64'(rr_pread),  64'd0);
      check("rst_pmem_write", 64'(rr_pwrite), 64'd0);
      check("rst_busy",       64'(rr_busy),   64'd0);
      check("rst_grant",      64'(rr_grant),  64'd0);
      check("rst_resp",       64'(rr_resp),   64'd0);

      step();
      step();
      rst_n = 1'b1;

      // Single read from port 1 at 0x40, memory answers three cycles later.
      set_addr(1, 32'h0000_0040);
      req_read = 4'b0010;
      step();
      check("rd_pmem_read",  64'(rr_pread),  64'd1);
      check("rd_pmem_write", 64'(rr_pwrite), 64'd0);
      check("rd_addr",       64'(rr_paddr),  64'h40);
      check("rd_grant",      64'(rr_grant),  64'd1);
      check("rd_busy",       64'(rr_busy),   64'd1);
      check("rd_no_early_resp", 64'(rr_resp), 64'd0);
      step();
      step();
      pmem_rdata = 64'hA5A5_0123_4567_89AB;
      pmem_resp  = 1'b1;
      #1;
      check("rd_resp_pulse", 64'(rr_resp),  64'b0010);
      check("rd_rdata",      rr_rdata,      64'hA5A5_0123_4567_89AB);
      step();
      req_read = '0;
      #1;
      // pmem_resp still high, but the block is back in IDLE: single pulse only.
      check("rd_done_busy",  64'(rr_busy),  64'd0);
      check("rd_resp_once",  64'(rr_resp),  64'd0);
      check("rd_rdata_pass", rr_rdata,      64'hA5A5_0123_4567_89AB);

      // Spurious response in IDLE.
      step();
      check("spur_resp",  64'(rr_resp),  64'd0);
      check("spur_busy",  64'(rr_busy),  64'd0);
      check("spur_read",  64'(rr_pread), 64'd0);
      check("spur_grant", 64'(rr_grant), 64'd1);
      pmem_resp = 1'b0;

      // Read and write together on port 0: write wins. rr_ptr is 2 here, and
      // port 0 is the only requester, so the search wraps to it.
      set_addr(0, 32'h0000_0080);
      req_wdata[0*LW +: LW] = 64'hDEAD_BEEF_CAFE_F00D;
      req_read  = 4'b0001;
      req_write = 4'b0001;
      step();
      check("rw_pmem_write", 64'(rr_pwrite), 64'd1);
      check("rw_pmem_read",  64'(rr_pread),  64'd0);
      check("rw_wdata",      rr_pwdata,      64'hDEAD_BEEF_CAFE_F00D);
      check("rw_addr",       64'(rr_paddr),  64'h80);
      check("rw_grant",      64'(rr_grant),  64'd0);
      // Requester drops mid-transaction: it still completes with a pulse.
      req_read  = '0;
      req_write = '0;
      step();
      check("drop_still_busy", 64'(rr_busy),   64'd1);
      check("drop_still_wr",   64'(rr_pwrite), 64'd1);
      pmem_resp = 1'b1;
      #1;
      check("drop_resp", 64'(rr_resp), 64'b0001);
      step();
      pmem_resp = 1'b0;
      check("drop_idle", 64'(rr_busy), 64'd0);

      // Reset in BUSY. rr_ptr is 1, so port 2 wins.
      set_addr(2, 32'h0000_0300);
      req_read = 4'b0100;
      step();
      check("mid_grant",     64'(rr_grant), 64'd2);
      check("mid_pmem_read", 64'(rr_pread), 64'd1);
      pmem_resp = 1'b1;
      rst_n     = 1'b0;
      #1;
      check("mid_rst_read",  64'(rr_pread), 64'd0);
      check("mid_rst_busy",  64'(rr_busy),  64'd0);
      check("mid_rst_resp",  64'(rr_resp),  64'd0);
      check("mid_rst_grant", 64'(rr_grant), 64'd0);
      step();
      pmem_resp = 1'b0;
      req_read  = '0;
      rst_n     = 1'b1;

      // All four ports request continuously: 0,1,2,3,0 with an IDLE gap each.
      // Port 0 first also shows rr_ptr came back to 0 after reset.
      for (int k = 0; k < NP; k++) set_addr(k, 32'(32'h100 * (k + 1)));
      req_read = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         step();
         check($sformatf("rr_grant_%0d", t), 64'(rr_grant), 64'(rr_order[t]));
         check($sformatf("rr_addr_%0d", t),  64'(rr_paddr),
               64'(32'h100 * (32'(rr_order[t]) + 1)));
         check($sformatf("fp_grant_%0d", t), 64'(fp_grant), 64'd0);
         pmem_resp = 1'b1;
         #1;
         check($sformatf("rr_resp_%0d", t), 64'(rr_resp), 64'(4'b0001 << rr_order[t]));
         step();
         pmem_resp = 1'b0;
         check($sformatf("rr_gap_%0d", t), 64'(rr_busy), 64'd0);
      end

      // Ports 0 and 2 only. Fixed priority keeps serving port 0; round-robin
      // (pointer now 1) alternates 2,0,2.
      req_read = 4'b0101;
      for (int t = 0; t < 3; t++) begin
         step();
         check($sformatf("fp_pair_grant_%0d", t), 64'(fp_grant), 64'd0);
         check($sformatf("fp_pair_addr_%0d", t),  64'(fp_paddr), 64'h100);
         check($sformatf("rr_pair_grant_%0d", t), 64'(rr_grant), 64'(rr_pair[t]));
         pmem_resp = 1'b1;
         #1;
         check($sformatf("fp_pair_resp_%0d", t), 64'(fp_resp), 64'b0001);
         step();
         pmem_resp = 1'b0;
      end
      req_read = '0;
      step();
      check("end_idle", 64'(rr_busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
